// File: rtl/ifetch_tag_stage.sv
// ifetch_tag_stage: per-warp PC/sleep tracking, warp select and icache lookup start.
// Define IFT_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round robin.
module ifetch_tag_stage #(
    parameter int NUM_WARP_PER_CORE       = 4,
    parameter int NUM_WARP_PER_CORE_LOG   = 2,
    parameter int ADDR_WIDTH              = 32,
    parameter int L1_CACHE_NUM_SETS_LOG   = 6,
    parameter int L1_CACHE_LINE_BYTES_LOG = 6,
    parameter int IFT_TO_IFD_BUS_WIDTH    = ADDR_WIDTH + NUM_WARP_PER_CORE_LOG
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_WARP_PER_CORE-1:0]     warp_en_bitmap,
    input  logic                             ifd_allowin,
    input  logic                             ifd_cache_miss,
    input  logic                             ifd_near_miss,
    input  logic [NUM_WARP_PER_CORE_LOG-1:0] ifd_cache_miss_warp_idx,
    input  logic [NUM_WARP_PER_CORE-1:0]     l2i_to_ift_wake_bitmap,
    input  logic                             wb_rollback_en,
    input  logic [NUM_WARP_PER_CORE_LOG-1:0] wb_rollback_warp_idx,
    input  logic [ADDR_WIDTH-1:0]            wb_rollback_pc,
    output logic                             ift_to_ifd_valid,
    output logic [IFT_TO_IFD_BUS_WIDTH-1:0]  ift_to_ifd_bus,
    output logic                             ift_to_icache_fetch_en,
    output logic [L1_CACHE_NUM_SETS_LOG-1:0] ift_to_icache_fetch_set_idx
);
    localparam int NW = NUM_WARP_PER_CORE;
    localparam int WL = NUM_WARP_PER_CORE_LOG;

    typedef logic [WL-1:0]         widx_t;
    typedef logic [ADDR_WIDTH-1:0] pc_t;

    pc_t                              pc_q [NW];
    pc_t                              pc_d [NW];
    logic [NW-1:0]                    sleep_q, sleep_d;
    logic [NW-1:0]                    miss_oh, nmiss_oh, rb_oh, ready;
    widx_t                            sel;
    pc_t                              sel_pc;
    logic                             issue;
    logic                             valid_q, valid_d;
    logic                             fetch_en_q, fetch_en_d;
    logic [IFT_TO_IFD_BUS_WIDTH-1:0]  bus_q, bus_d;
    logic [L1_CACHE_NUM_SETS_LOG-1:0] set_q, set_d;

    always_comb begin
        miss_oh  = '0;
        nmiss_oh = '0;
        rb_oh    = '0;
        miss_oh[ifd_cache_miss_warp_idx]  = ifd_cache_miss;
        nmiss_oh[ifd_cache_miss_warp_idx] = ifd_near_miss;
        rb_oh[wb_rollback_warp_idx]       = wb_rollback_en;
    end

    // a wake seen this cycle makes the warp eligible immediately
    assign ready = warp_en_bitmap
                 & ~(sleep_q & ~l2i_to_ift_wake_bitmap)
                 & ~miss_oh & ~nmiss_oh & ~rb_oh;
    assign issue = ifd_allowin & (|ready);

`ifdef IFT_FIXED_PRIORITY_EN
    always_comb begin
        sel = '0;
        for (int i = NW - 1; i >= 0; i--) begin
            if (ready[i]) sel = widx_t'(i);
        end
    end
`else
    widx_t rr_q;
    widx_t cand;
    logic  found;

    always_comb begin
        sel   = rr_q;
        cand  = rr_q;
        found = 1'b0;
        for (int i = 0; i < NW; i++) begin
            cand = rr_q + widx_t'(i);
            if (!found && ready[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (issue) begin
            rr_q <= sel + widx_t'(1);
        end
    end
`endif

    assign sel_pc = pc_q[sel];

    always_comb begin
        for (int w = 0; w < NW; w++) begin
            pc_d[w] = pc_q[w];
            if (rb_oh[w]) begin
                pc_d[w] = wb_rollback_pc;
            end else if (miss_oh[w] | nmiss_oh[w]) begin
                pc_d[w] = pc_q[w] - pc_t'(4);
            end else if (issue && sel == widx_t'(w)) begin
                pc_d[w] = pc_q[w] + pc_t'(4);
            end
        end
        sleep_d = (sleep_q & ~l2i_to_ift_wake_bitmap) | miss_oh;
    end

    always_comb begin
        valid_d    = valid_q;
        fetch_en_d = 1'b0;
        bus_d      = bus_q;
        set_d      = set_q;
        if (ifd_allowin) begin
            valid_d    = issue;
            fetch_en_d = issue;
            bus_d      = {sel_pc, sel};
            set_d      = sel_pc[L1_CACHE_LINE_BYTES_LOG +: L1_CACHE_NUM_SETS_LOG];
        end else if (wb_rollback_en && wb_rollback_warp_idx == bus_q[WL-1:0]) begin
            // a held fetch whose warp is being redirected is stale
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NW; w++) pc_q[w] <= '0;
            sleep_q    <= '0;
            valid_q    <= 1'b0;
            fetch_en_q <= 1'b0;
            bus_q      <= '0;
            set_q      <= '0;
        end else begin
            for (int w = 0; w < NW; w++) pc_q[w] <= pc_d[w];
            sleep_q    <= sleep_d;
            valid_q    <= valid_d;
            fetch_en_q <= fetch_en_d;
            bus_q      <= bus_d;
            set_q      <= set_d;
        end
    end

    assign ift_to_ifd_valid            = valid_q;
    assign ift_to_ifd_bus              = bus_q;
    assign ift_to_icache_fetch_en      = fetch_en_q;
    assign ift_to_icache_fetch_set_idx = set_q;

endmodule

// File: tb/tb_ifetch_tag_stage.sv
// tb_ifetch_tag_stage: directed vectors for ifetch_tag_stage.
// Expected values are hand-computed; IFT_FIXED_PRIORITY_EN selects the arbiter table.
module tb_ifetch_tag_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  warp_en_bitmap;
    logic        ifd_allowin;
    logic        ifd_cache_miss;
    logic        ifd_near_miss;
    logic [1:0]  ifd_cache_miss_warp_idx;
    logic [3:0]  l2i_to_ift_wake_bitmap;
    logic        wb_rollback_en;
    logic [1:0]  wb_rollback_warp_idx;
    logic [31:0] wb_rollback_pc;
    logic        ift_to_ifd_valid;
    logic [33:0] ift_to_ifd_bus;
    logic        ift_to_icache_fetch_en;
    logic [5:0]  ift_to_icache_fetch_set_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_tag_stage dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .warp_en_bitmap              (warp_en_bitmap),
        .ifd_allowin                 (ifd_allowin),
        .ifd_cache_miss              (ifd_cache_miss),
        .ifd_near_miss               (ifd_near_miss),
        .ifd_cache_miss_warp_idx     (ifd_cache_miss_warp_idx),
        .l2i_to_ift_wake_bitmap      (l2i_to_ift_wake_bitmap),
        .wb_rollback_en              (wb_rollback_en),
        .wb_rollback_warp_idx        (wb_rollback_warp_idx),
        .wb_rollback_pc              (wb_rollback_pc),
        .ift_to_ifd_valid            (ift_to_ifd_valid),
        .ift_to_ifd_bus              (ift_to_ifd_bus),
        .ift_to_icache_fetch_en      (ift_to_icache_fetch_en),
        .ift_to_icache_fetch_set_idx (ift_to_icache_fetch_set_idx)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expo(input string tag, input logic v, input logic fe,
                        input logic [31:0] pc, input logic [1:0] w);
        logic [33:0] eb;
        eb = {pc, w};
        chk({tag, ".valid"}, 64'(ift_to_ifd_valid), 64'(v));
        chk({tag, ".fetch_en"}, 64'(ift_to_icache_fetch_en), 64'(fe));
        if (v) chk({tag, ".bus"}, 64'(ift_to_ifd_bus), 64'(eb));
    endtask

    task automatic chk_set(input string tag, input logic [5:0] s);
        chk({tag, ".set"}, 64'(ift_to_icache_fetch_set_idx), 64'(s));
    endtask

    logic [31:0] t5_pc [5];
    logic [1:0]  t5_w  [5];

    initial begin
        rst_n = 1'b0;
        warp_en_bitmap = '0;
        ifd_allowin = 1'b0;
        ifd_cache_miss = 1'b0;
        ifd_near_miss = 1'b0;
        ifd_cache_miss_warp_idx = '0;
        l2i_to_ift_wake_bitmap = '0;
        wb_rollback_en = 1'b0;
        wb_rollback_warp_idx = '0;
        wb_rollback_pc = '0;
        #3;
        chk("rst.valid", 64'(ift_to_ifd_valid), 64'(0));
        chk("rst.fetch_en", 64'(ift_to_icache_fetch_en), 64'(0));
        chk("rst.bus", 64'(ift_to_ifd_bus), 64'(0));
        chk("rst.set", 64'(ift_to_icache_fetch_set_idx), 64'(0));

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        warp_en_bitmap = 4'b0001;
        ifd_allowin = 1'b1;

        step(); expo("t1a", 1, 1, 32'h0, 2'd0); chk_set("t1a", 6'd0);
        step(); expo("t1b", 1, 1, 32'h4, 2'd0);
        step(); expo("t1c", 1, 1, 32'h8, 2'd0);

        warp_en_bitmap = 4'b0000;
        step(); expo("t2", 0, 0, 32'h0, 2'd0);

        warp_en_bitmap = 4'b0001;
        ifd_cache_miss = 1'b1;
        step(); expo("t3miss", 0, 0, 32'h0, 2'd0);
        ifd_cache_miss = 1'b0;
        step(); expo("t3slp1", 0, 0, 32'h0, 2'd0);
        step(); expo("t3slp2", 0, 0, 32'h0, 2'd0);
        l2i_to_ift_wake_bitmap = 4'b0001;
        step(); expo("t3wake", 1, 1, 32'h8, 2'd0); chk_set("t3wake", 6'd0);
        l2i_to_ift_wake_bitmap = 4'b0000;

        ifd_cache_miss = 1'b1;
        l2i_to_ift_wake_bitmap = 4'b0001;
        step(); expo("t3mw", 0, 0, 32'h0, 2'd0);
        ifd_cache_miss = 1'b0;
        l2i_to_ift_wake_bitmap = 4'b0000;
        step(); expo("t3mwslp", 0, 0, 32'h0, 2'd0);
        l2i_to_ift_wake_bitmap = 4'b0001;
        step(); expo("t3w2", 1, 1, 32'h8, 2'd0);
        l2i_to_ift_wake_bitmap = 4'b0000;

        ifd_near_miss = 1'b1;
        step(); expo("t4nm", 0, 0, 32'h0, 2'd0);
        ifd_near_miss = 1'b0;
        step(); expo("t4a", 1, 1, 32'h8, 2'd0);
        step(); expo("t4b", 1, 1, 32'hC, 2'd0);

        wb_rollback_en = 1'b1;
        wb_rollback_pc = 32'h100;
        step(); expo("t6rb", 0, 0, 32'h0, 2'd0);
        wb_rollback_en = 1'b0;
        step(); expo("t6a", 1, 1, 32'h100, 2'd0); chk_set("t6a", 6'd4);
        step(); expo("t6b", 1, 1, 32'h104, 2'd0); chk_set("t6b", 6'd4);

        ifd_allowin = 1'b0;
        step(); expo("t6h1", 1, 0, 32'h104, 2'd0);
        step(); expo("t6h2", 1, 0, 32'h104, 2'd0); chk_set("t6h2", 6'd4);
        wb_rollback_en = 1'b1;
        wb_rollback_pc = 32'h1FC0;
        step(); expo("t6hrb", 0, 0, 32'h0, 2'd0);
        chk("t6hrb.bus", 64'(ift_to_ifd_bus), 64'({32'h104, 2'd0}));
        wb_rollback_en = 1'b0;
        ifd_allowin = 1'b1;
        step(); expo("t6c", 1, 1, 32'h1FC0, 2'd0); chk_set("t6c", 6'h3F);

        rst_n = 1'b0;
        #2;
        chk("rst2.valid", 64'(ift_to_ifd_valid), 64'(0));
        rst_n = 1'b1;
        warp_en_bitmap = 4'b1111;
`ifdef IFT_FIXED_PRIORITY_EN
        t5_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        t5_w  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        t5_pc = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4};
        t5_w  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            expo($sformatf("t5_%0d", i), 1, 1, t5_pc[i], t5_w[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
